fetch: RTL

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction-fetch block.
//   RESET_PC_DEFAULT : default first fetch address after reset.
//   state_e          : fetch FSM states (REQ / HOLD / KILL).
//   align_word()     : forces an address onto a 32-bit word boundary.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request outstanding (or about to be issued)
    ST_HOLD = 2'd1,  // instruction presented, waiting for the consumer
    ST_KILL = 2'd2   // waiting out a request whose word will be dropped
  } state_e;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch.sv
// fetch -- single-outstanding-request instruction fetch unit.
// Ports:
//   CLK, RST            clock; synchronous active-low reset
//   imem_req/imem_addr  request to instruction memory (held until imem_ack)
//   imem_ack/imem_rdata memory response
//   Ins/nextPC          fetched word and its fall-through address
//   ins_valid/ins_ready valid/ready handshake towards decode
//   redirect/newPC      control-flow change from execute
//   addr_err            one-cycle pulse on a misaligned redirect target
//   fetch_count         number of completed instruction transfers
// Every output comes straight from a register.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Ins,
  output logic [31:0] nextPC,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] newPC,
  output logic        addr_err,
  output logic [31:0] fetch_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        ins_valid_q, ins_valid_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] redir_pc;
  logic        redir_misaligned;
  logic [31:0] pc_plus4;
  logic        transfer;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    imem_req_d       = imem_req_q;
    imem_addr_d      = imem_addr_q;
    ins_d            = ins_q;
    next_pc_d        = next_pc_q;
    ins_valid_d      = ins_valid_q;
    addr_err_d       = 1'b0;
    fetch_count_d    = fetch_count_q;
    redir_pc         = align_word(newPC);
    redir_misaligned = |newPC[1:0];
    pc_plus4         = pc_q + 32'd4;  // wraps naturally at 2^32
    transfer         = ins_valid_q & ins_ready;

    case (state_q)
      ST_REQ: begin
        if (!imem_req_q) begin
          // Only reachable straight out of reset: nothing is outstanding,
          // so any ack seen here is stale and ignored.
          imem_req_d = 1'b1;
          if (redirect) begin
            pc_d        = redir_pc;
            addr_err_d  = redir_misaligned;
            imem_addr_d = redir_pc;
          end else begin
            imem_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if (redirect) begin
            // Returned word belongs to the wrong path: drop it and issue
            // the redirected request immediately.
            pc_d        = redir_pc;
            addr_err_d  = redir_misaligned;
            imem_addr_d = redir_pc;
          end else begin
            ins_d       = imem_rdata;
            next_pc_d   = pc_plus4;
            ins_valid_d = 1'b1;
            pc_d        = pc_plus4;
            imem_req_d  = 1'b0;
            state_d     = ST_HOLD;
          end
        end else if (redirect) begin
          // The request cannot be withdrawn; keep it and discard its data.
          pc_d       = redir_pc;
          addr_err_d = redir_misaligned;
          state_d    = ST_KILL;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          // Redirect beats a same-cycle transfer; the word is not counted.
          ins_valid_d = 1'b0;
          pc_d        = redir_pc;
          addr_err_d  = redir_misaligned;
          imem_req_d  = 1'b1;
          imem_addr_d = redir_pc;
          state_d     = ST_REQ;
        end else if (transfer) begin
          ins_valid_d   = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          imem_req_d    = 1'b1;
          imem_addr_d   = pc_q;
          state_d       = ST_REQ;
        end
      end

      ST_KILL: begin
        if (imem_ack) begin
          // Stale word dropped; a redirect in this same cycle still wins.
          imem_req_d = 1'b1;
          state_d    = ST_REQ;
          if (redirect) begin
            pc_d        = redir_pc;
            addr_err_d  = redir_misaligned;
            imem_addr_d = redir_pc;
          end else begin
            imem_addr_d = pc_q;
          end
        end else if (redirect) begin
          pc_d       = redir_pc;
          addr_err_d = redir_misaligned;
        end
      end

      default: begin
        state_d    = ST_REQ;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      ins_q         <= 32'd0;
      next_pc_q     <= 32'd0;
      ins_valid_q   <= 1'b0;
      addr_err_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      ins_q         <= ins_d;
      next_pc_q     <= next_pc_d;
      ins_valid_q   <= ins_valid_d;
      addr_err_q    <= addr_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign Ins         = ins_q;
  assign nextPC      = next_pc_q;
  assign ins_valid   = ins_valid_q;
  assign addr_err    = addr_err_q;
  assign fetch_count = fetch_count_q;

endmodule
